// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_WAIT_HI,
      ST_WAIT_LO
   } arb_state_e;

   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Pointer width for an n-way round robin; never zero so ports stay legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first request at or above ptr, wrapping.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic found;

   // Distance k from the pointer is tried in order; candidate i matches when ptr+k lands on it mod N.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] &&
                ((int'(ptr) + k == i) || (int'(ptr) + k == i + N))) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to force-terminate messages that stall for MSG_TIMEOUT cycles.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int BUSY_GUARD  = 16,
   parameter int MSG_TIMEOUT = 12_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic [7:0]           tx_data,
   output logic                 tx_data_valid,
   input  logic                 tx_busy,
   output logic                 err,
   output logic                 abort
);

   localparam int PW = ptr_width(NUM_REQ);
   localparam int GW = $clog2(BUSY_GUARD + 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d, pick;
   logic [PW-1:0]      ptr_q, ptr_d, gnt_idx, ptr_after;
   logic [7:0]         tx_data_q, tx_data_d, sel_data;
   logic               tx_valid_q, tx_valid_d;
   logic               err_q, err_d;
   logic               last_q, last_d;
   logic [GW-1:0]      guard_q, guard_d;
   logic               sel_valid, sel_last;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = $clog2(MSG_TIMEOUT + 1);
   logic [TW-1:0] tout_q, tout_d;
   logic          abort_q, abort_d;
`else
   // MSG_TIMEOUT only matters when the timeout is built in; abort is constant low here.
   localparam logic ABORT_TIE = 1'b0 & (MSG_TIMEOUT > 0);
`endif

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (pick)
   );

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_q == ST_ACCEPT) && grant_q[gi] && req_valid[gi];
   end

   // Steer the granted requester's byte, valid and last onto shared selection wires.
   always_comb begin
      sel_data  = 8'h00;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            sel_data  = req_data[8*i +: 8];
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            gnt_idx   = PW'(i);
         end
      end
   end

   assign ptr_after = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
      err_d      = err_q;
      last_d     = last_q;
      guard_d    = guard_q;
`ifdef UART_ARB_TIMEOUT_EN
      tout_d     = tout_q;
      abort_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               state_d = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            if (sel_valid) begin
               tx_data_d  = sel_data;
               tx_valid_d = 1'b1;
               last_d     = sel_last;
               guard_d    = '0;
               state_d    = ST_WAIT_HI;
`ifdef UART_ARB_TIMEOUT_EN
               tout_d     = '0;
            end else if (tout_q == TW'(MSG_TIMEOUT - 1)) begin
               // Close the stalled line ourselves so the receiver sees a terminated message.
               tx_data_d  = ASCII_LF;
               tx_valid_d = 1'b1;
               last_d     = 1'b1;
               guard_d    = '0;
               tout_d     = '0;
               abort_d    = 1'b1;
               state_d    = ST_WAIT_HI;
            end else begin
               tout_d     = tout_q + TW'(1);
`endif
            end
         end
         ST_WAIT_HI: begin
            if (tx_busy) begin
               state_d = ST_WAIT_LO;
            end else if (guard_q == GW'(BUSY_GUARD - 1)) begin
               err_d   = 1'b1;
               state_d = ST_WAIT_LO;
            end else begin
               guard_d = guard_q + GW'(1);
            end
         end
         ST_WAIT_LO: begin
            if (!tx_busy) begin
               if (last_q) begin
                  grant_d = '0;
                  ptr_d   = ptr_after;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ACCEPT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         ptr_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
         last_q     <= 1'b0;
         guard_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         tout_q     <= '0;
         abort_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         err_q      <= err_d;
         last_q     <= last_d;
         guard_q    <= guard_d;
`ifdef UART_ARB_TIMEOUT_EN
         tout_q     <= tout_d;
         abort_q    <= abort_d;
`endif
      end
   end

   assign grant         = grant_q;
   assign tx_data       = tx_data_q;
   assign tx_data_valid = tx_valid_q;
   assign err           = err_q;
`ifdef UART_ARB_TIMEOUT_EN
   assign abort         = abort_q;
`else
   assign abort         = ABORT_TIE;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy model and scripted requesters.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int N          = 3;
   localparam int FRAME      = 6;
   localparam int TB_TIMEOUT = 100;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N*8-1:0] req_data;
   logic [N-1:0]   req_valid, req_last, req_ready, grant;
   logic [7:0]     tx_data;
   logic           tx_data_valid, tx_busy, err, abort;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ     (N),
      .BUSY_GUARD  (16),
      .MSG_TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_data      (req_data),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .grant         (grant),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_busy       (tx_busy),
      .err           (err),
      .abort         (abort)
   );

   // Scripted requesters: each walks its byte table, advancing on valid & ready.
   logic [7:0] m_byte [N][8];
   logic       m_last [N][8];
   int         m_len [N];
   int         stall_at [N];
   logic       go [N];
   logic       clr [N];
   int         pos [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign req_valid[gi]       = go[gi] && (pos[gi] < m_len[gi]) && (pos[gi] != stall_at[gi]);
      assign req_data[8*gi +: 8] = m_byte[gi][pos[gi][2:0]];
      assign req_last[gi]        = m_last[gi][pos[gi][2:0]];
      always @(posedge clk) begin
         if (clr[gi]) pos[gi] <= 0;
         else if (req_valid[gi] && req_ready[gi]) pos[gi] <= pos[gi] + 1;
      end
   end

   // uart_tx stand-in: busy rises the cycle after data_valid and stays up FRAME cycles.
   int   busy_cnt;
   logic busy_en;
   always @(posedge clk) begin
      if (rst) begin
         tx_busy  <= 1'b0;
         busy_cnt <= 0;
      end else if (tx_data_valid && busy_en) begin
         tx_busy  <= 1'b1;
         busy_cnt <= FRAME;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         tx_busy  <= 1'b0;
         busy_cnt <= 0;
      end
   end

   logic [7:0]   log_byte [$];
   logic [N-1:0] log_gnt [$];
   int           abort_cnt = 0;
   int           cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && tx_data_valid) begin
         log_byte.push_back(tx_data);
         log_gnt.push_back(grant);
         $display("[%0d] tx byte 0x%02h grant %b", cyc, tx_data, grant);
      end
      if (abort) abort_cnt++;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input int r, input int n, input logic [63:0] bytes, input logic [7:0] lasts);
      for (int k = 0; k < 8; k++) begin
         m_byte[r][k] = bytes[8*k +: 8];
         m_last[r][k] = lasts[k];
      end
      m_len[r] = n;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         go[i]       = 1'b0;
         clr[i]      = 1'b1;
         stall_at[i] = -1;
      end
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) clr[i] = 1'b0;
      tick();
   endtask

   function automatic logic all_done();
      logic d;
      d = (grant == '0) && !tx_busy;
      for (int i = 0; i < N; i++)
         if (go[i] && pos[i] < m_len[i]) d = 1'b0;
      return d;
   endfunction

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!all_done() && k < 2000) begin
         tick();
         k++;
      end
      check({tag, " done"}, 32'(all_done()), 1);
   endtask

   // Compare transmitted bytes since start against a table; gnts holds one nibble per entry.
   task automatic expect_log(input string tag, input int start, input int n,
                             input logic [95:0] bytes, input logic [47:0] gnts);
      check({tag, " count"}, log_byte.size() - start, n);
      for (int k = 0; k < n; k++) begin
         if (start + k < log_byte.size()) begin
            check($sformatf("%s byte%0d", tag, k), log_byte[start+k], bytes[8*k +: 8]);
            check($sformatf("%s gnt%0d", tag, k), log_gnt[start+k], gnts[4*k +: N]);
         end
      end
   endtask

   initial begin
      int start, k, n, t0, t1, rel, acc;
      logic [N-1:0] pg;
      busy_en = 1'b1;
      for (int i = 0; i < N; i++) begin
         m_len[i] = 0;
         load(i, 0, 64'h0, 8'h0);
      end

      // Reset values
      do_reset();
      check("rst grant", grant, 0);
      check("rst req_ready", req_ready, 0);
      check("rst tx_data", tx_data, 8'h00);
      check("rst tx_valid", tx_data_valid, 0);
      check("rst err", err, 0);
      check("rst abort", abort, 0);

      // Single requester 1 sends "OK\n"
      start = log_byte.size();
      load(1, 3, 64'h0A4B4F, 8'b100);
      go[1] = 1'b1;
      tick();
      check("ok grant c1", grant, 3'b010);
      check("ok ready c1", req_ready, 3'b010);
      tick();
      check("ok tx_valid c2", tx_data_valid, 1);
      check("ok tx_data c2", tx_data, 8'h4F);
      check("ok ready c2", req_ready, 0);
      wait_done("ok");
      expect_log("ok", start, 3, 96'h0A4B4F, 48'h222);
      check("ok grant end", grant, 0);

      // Pointer now 2: r2 beats r0, then wraps to r0
      start = log_byte.size();
      load(0, 1, 64'h01, 8'b1);
      load(2, 1, 64'h02, 8'b1);
      go[0] = 1'b1;
      go[2] = 1'b1;
      tick();
      check("wrap grant", grant, 3'b100);
      wait_done("wrap");
      expect_log("wrap", start, 2, 96'h0102, 48'h14);

      // All three request together after reset
      do_reset();
      start = log_byte.size();
      load(0, 4, 64'h0A630A61, 8'b1010);
      load(1, 2, 64'h0A62, 8'b10);
      load(2, 3, 64'h0A7978, 8'b100);
      for (int i = 0; i < N; i++) go[i] = 1'b1;
      tick();
      check("all first grant", grant, 3'b001);
      wait_done("all");
      expect_log("all", start, 9, 96'h0A630A79780A620A61, 48'h114442211);

      // r2 requests while r0 holds a message
      do_reset();
      start = log_byte.size();
      load(0, 3, 64'h332211, 8'b100);
      load(2, 1, 64'h44, 8'b1);
      go[0] = 1'b1;
      k = 0;
      while (!tx_data_valid && k < 50) begin
         tick();
         k++;
      end
      go[2] = 1'b1;
      rel = -1;
      acc = -1;
      pg  = grant;
      k   = 0;
      while (acc < 0 && k < 500) begin
         tick();
         k++;
         if (pg == 3'b001 && grant == 3'b000) rel = cyc;
         if (req_valid[2] && req_ready[2]) acc = cyc;
         pg = grant;
      end
      check("hold release to accept", acc - rel, 1);
      wait_done("hold");
      expect_log("hold", start, 4, 96'h44332211, 48'h4111);

      // tx_busy never rises: err after the guard, FSM still advances
      do_reset();
      busy_en = 1'b0;
      start = log_byte.size();
      load(1, 2, 64'h6655, 8'b10);
      go[1] = 1'b1;
      k = 0;
      while (!tx_data_valid && k < 50) begin
         tick();
         k++;
      end
      t0 = cyc;
      check("guard err before", err, 0);
      k = 0;
      while (!err && k < 100) begin
         tick();
         k++;
      end
      t1 = cyc;
      check("guard err delay", t1 - t0, 16);
      wait_done("guard");
      expect_log("guard", start, 2, 96'h6655, 48'h22);
      check("guard err sticky", err, 1);
      busy_en = 1'b1;

      // Reset during WAIT_LO of byte 2 of r1's message, after r0 moved the pointer
      do_reset();
      check("rst clears err", err, 0);
      load(0, 1, 64'h01, 8'b1);
      go[0] = 1'b1;
      wait_done("pre");
      load(1, 3, 64'h040302, 8'b100);
      go[1] = 1'b1;
      n = 0;
      k = 0;
      while (n < 2 && k < 500) begin
         tick();
         k++;
         if (tx_data_valid) n++;
      end
      k = 0;
      while (!tx_busy && k < 50) begin
         tick();
         k++;
      end
      tick();
      rst = 1'b1;
      tick();
      check("midrst grant", grant, 0);
      check("midrst tx_valid", tx_data_valid, 0);
      check("midrst ready", req_ready, 0);
      do_reset();
      load(0, 1, 64'h0A, 8'b1);
      load(1, 1, 64'h0A, 8'b1);
      load(2, 1, 64'h0A, 8'b1);
      for (int i = 0; i < N; i++) go[i] = 1'b1;
      tick();
      check("midrst ptr zero", grant, 3'b001);
      wait_done("midrst");

`ifdef UART_ARB_TIMEOUT_EN
      // Requester 1 stalls after two bytes; the arbiter closes the line
      do_reset();
      load(1, 4, 64'h34333231, 8'b1000);
      stall_at[1] = 2;
      go[1] = 1'b1;
      n = 0;
      k = 0;
      while (n < 2 && k < 500) begin
         tick();
         k++;
         if (tx_data_valid) n++;
      end
      k = 0;
      while (!tx_busy && k < 50) begin
         tick();
         k++;
      end
      k = 0;
      while (tx_busy && k < 50) begin
         tick();
         k++;
      end
      t0 = cyc;
      k = 0;
      while (!tx_data_valid && k < 400) begin
         tick();
         k++;
      end
      check("tout delay", cyc - t0, TB_TIMEOUT + 1);
      check("tout byte", tx_data, 8'h0A);
      check("tout abort", abort, 1);
      check("tout no ready", req_ready, 0);
      tick();
      check("tout abort pulse", abort, 0);
      k = 0;
      while (grant != '0 && k < 100) begin
         tick();
         k++;
      end
      check("tout release", grant, 0);
      check("tout pos", pos[1], 2);
      do_reset();
`else
      check("abort tied low", abort_cnt, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
